// File: rtl/ibex_prefetch_pkg.sv
// Shared types and helpers for the multi-request prefetch buffer.
package ibex_prefetch_pkg;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } fetch_entry_t;

   localparam logic [31:0] AddrIncr = 32'd4;

   // Counter width able to hold the values 0..num
   function automatic int unsigned cnt_width(input int unsigned num);
      return (num > 0) ? $clog2(num + 1) : 1;
   endfunction

endpackage

// File: rtl/ibex_prefetch_req_tracker.sv
// Bus request bookkeeping: held request, fetch address, outstanding and discard counters.
module ibex_prefetch_req_tracker import ibex_prefetch_pkg::*; #(
   parameter int unsigned NumReqs   = 2,
   parameter int unsigned FifoDepth = 3,
   parameter int unsigned CntW      = cnt_width(NumReqs),
   parameter int unsigned FifoCntW  = cnt_width(FifoDepth)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                branch_i,
   input  logic [31:0]         addr_i,
   input  logic                stop_i,
   input  logic [FifoCntW-1:0] fifo_cnt_i,
   input  logic                instr_gnt_i,
   input  logic                instr_rvalid_i,
   output logic                instr_req_o,
   output logic [31:0]         instr_addr_o,
   output logic                issue_o,
   output logic                discard_now_o,
   output logic [CntW-1:0]     outstanding_o
);

   logic            held_q, held_d;
   logic [31:0]     stored_addr_q, stored_addr_d;
   logic [31:0]     fetch_addr_q, fetch_addr_d;
   logic [CntW-1:0] outst_q, outst_d;
   logic [CntW-1:0] discard_q, discard_d;
   logic [31:0]     branch_addr;
   logic            gnt_now;

   assign branch_addr   = {addr_i[31:2], 2'b00};
   assign outstanding_o = outst_q;

   always_comb begin
      issue_o       = req_i & ~held_q & ~stop_i
                    & (32'(outst_q) < NumReqs)
                    & (branch_i | ((32'(fifo_cnt_i) + 32'(outst_q)) < FifoDepth));
      instr_req_o   = held_q | issue_o;
      instr_addr_o  = held_q ? stored_addr_q : (branch_i ? branch_addr : fetch_addr_q);
      gnt_now       = instr_req_o & instr_gnt_i;
      discard_now_o = instr_rvalid_i & (branch_i | (discard_q != '0));

      held_d        = instr_req_o & ~instr_gnt_i;
      stored_addr_d = held_d ? instr_addr_o : stored_addr_q;

      fetch_addr_d = fetch_addr_q;
      if (issue_o) begin
         fetch_addr_d = instr_addr_o + AddrIncr;
      end else if (branch_i) begin
         fetch_addr_d = branch_addr;
      end

      outst_d = outst_q + CntW'(gnt_now) - CntW'(instr_rvalid_i);

      // Everything in flight at a branch (granted or still held) belongs to the old stream
      discard_d = discard_q;
      if (branch_i) begin
         discard_d = outst_q + CntW'(held_q) - CntW'(instr_rvalid_i);
      end else if (discard_now_o) begin
         discard_d = discard_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         held_q        <= 1'b0;
         stored_addr_q <= '0;
         fetch_addr_q  <= '0;
         outst_q       <= '0;
         discard_q     <= '0;
      end else begin
         held_q        <= held_d;
         stored_addr_q <= stored_addr_d;
         fetch_addr_q  <= fetch_addr_d;
         outst_q       <= outst_d;
         discard_q     <= discard_d;
      end
   end

endmodule

// File: rtl/ibex_prefetch_buffer_mq.sv
// Prefetch buffer with NumReqs outstanding bus requests and a FifoDepth word FIFO.
// Optional IBEX_PREFETCH_ERR_STOP_EN: a fetched error entry stops prefetching until a branch.
module ibex_prefetch_buffer_mq import ibex_prefetch_pkg::*; #(
   parameter int unsigned NumReqs   = 2,
   parameter int unsigned FifoDepth = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        branch_i,
   input  logic [31:0] addr_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] rdata_o,
   output logic [31:0] addr_o,
   output logic        err_o,
   output logic        instr_req_o,
   input  logic        instr_gnt_i,
   output logic [31:0] instr_addr_o,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   input  logic        instr_rvalid_i,
   output logic        busy_o
);

   localparam int unsigned CntW     = cnt_width(NumReqs);
   localparam int unsigned FifoCntW = cnt_width(FifoDepth);
   localparam int unsigned PtrW     = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

   fetch_entry_t        fifo_q [FifoDepth];
   logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [FifoCntW-1:0] cnt_q, cnt_d;
   logic [31:0]         addr_q, addr_d;
   logic [CntW-1:0]     outstanding;
   logic                issue, discard_now, push, pop, stop_c;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (32'(p) == FifoDepth - 1) ? '0 : p + PtrW'(1);
   endfunction

   ibex_prefetch_req_tracker #(
      .NumReqs   (NumReqs),
      .FifoDepth (FifoDepth),
      .CntW      (CntW),
      .FifoCntW  (FifoCntW)
   ) u_tracker (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_i          (req_i),
      .branch_i       (branch_i),
      .addr_i         (addr_i),
      .stop_i         (stop_c),
      .fifo_cnt_i     (cnt_q),
      .instr_gnt_i    (instr_gnt_i),
      .instr_rvalid_i (instr_rvalid_i),
      .instr_req_o    (instr_req_o),
      .instr_addr_o   (instr_addr_o),
      .issue_o        (issue),
      .discard_now_o  (discard_now),
      .outstanding_o  (outstanding)
   );

   assign valid_o = (cnt_q != '0);
   assign rdata_o = fifo_q[head_q].rdata;
   assign err_o   = fifo_q[head_q].err;
   assign addr_o  = addr_q;
   assign busy_o  = instr_req_o | (outstanding != '0);

   assign push = instr_rvalid_i & ~discard_now;
   assign pop  = valid_o & ready_i & ~branch_i;

   // A branch empties the FIFO and retargets the head address; it overrides any pop
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      addr_d = addr_q;
      if (branch_i) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
         addr_d = {addr_i[31:2], 2'b00};
      end else begin
         if (push) tail_d = ptr_inc(tail_q);
         if (pop) begin
            head_d = ptr_inc(head_q);
            addr_d = addr_q + AddrIncr;
         end
         if (push && !pop) begin
            cnt_d = cnt_q + FifoCntW'(1);
         end else if (pop && !push) begin
            cnt_d = cnt_q - FifoCntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         addr_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FifoDepth; i++) fifo_q[i] <= '0;
      end else if (push) begin
         fifo_q[tail_q] <= '{rdata: instr_rdata_i, err: instr_err_i};
      end
   end

`ifdef IBEX_PREFETCH_ERR_STOP_EN
   logic stop_q, stop_d;

   always_comb begin
      stop_d = stop_q;
      if (branch_i) begin
         stop_d = 1'b0;
      end else if (push && instr_err_i) begin
         stop_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) stop_q <= 1'b0;
      else       stop_q <= stop_d;
   end

   assign stop_c = stop_q & ~branch_i;
`else
   assign stop_c = 1'b0;
`endif

   // The issue rule reserves a slot for every in-flight word, so a push never finds the FIFO full
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(push && !pop && (32'(cnt_q) == FifoDepth)));
         assert (!(issue && stop_c));
      end
   end

endmodule

// File: tb/tb_ibex_prefetch_buffer_mq.sv
// Randomized and directed bench for ibex_prefetch_buffer_mq against a queue-based fetch model.
module tb_ibex_prefetch_buffer_mq;

   localparam int unsigned NumReqs   = 2;
   localparam int unsigned FifoDepth = 3;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i, branch_i, ready_i;
   logic [31:0] addr_i;
   logic        valid_o, err_o, instr_req_o, busy_o;
   logic [31:0] rdata_o, addr_o, instr_addr_o;
   logic        instr_gnt_i, instr_err_i, instr_rvalid_i;
   logic [31:0] instr_rdata_i;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   ibex_prefetch_buffer_mq #(.NumReqs(NumReqs), .FifoDepth(FifoDepth)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_i          (req_i),
      .branch_i       (branch_i),
      .addr_i         (addr_i),
      .ready_i        (ready_i),
      .valid_o        (valid_o),
      .rdata_o        (rdata_o),
      .addr_o         (addr_o),
      .err_o          (err_o),
      .instr_req_o    (instr_req_o),
      .instr_gnt_i    (instr_gnt_i),
      .instr_addr_o   (instr_addr_o),
      .instr_rdata_i  (instr_rdata_i),
      .instr_err_i    (instr_err_i),
      .instr_rvalid_i (instr_rvalid_i),
      .busy_o         (busy_o)
   );

   // Model state: bus requests in flight, delivered words, the pending ungranted request
   typedef struct { logic [31:0] addr; bit stale; } req_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; logic err; } ent_t;
   req_t        infl[$];
   ent_t        fifo[$];
   bit          pend_v, pend_stale, stop_m;
   logic [31:0] pend_addr, fetch_a;

   function automatic logic [31:0] memdata(input logic [31:0] a);
      return a ^ 32'hC3A5_5A3C;
   endfunction

   function automatic logic memerr(input logic [31:0] a);
      return a[14] && (a[5:2] == 4'd1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      infl.delete();
      fifo.delete();
      pend_v = 0; pend_stale = 0; stop_m = 0;
      pend_addr = '0; fetch_a = '0;
   endtask

   // One clock cycle: drive inputs, compare DUT against the model, advance the model
   task automatic step(input bit rq, input bit br, input logic [31:0] ba, input bit rdy,
                       input bit g, input bit rv);
      logic [31:0] tgt, e_addr;
      bit held, iss, e_req, stop_eff, rv_eff, do_pop;
      req_t r;
      @(negedge clk_i);
      req_i = rq; branch_i = br; addr_i = ba; ready_i = rdy; instr_gnt_i = g;
      rv_eff = rv && (infl.size() != 0);
      instr_rvalid_i = rv_eff;
      if (rv_eff) begin
         instr_rdata_i = memdata(infl[0].addr);
         instr_err_i   = memerr(infl[0].addr);
      end else begin
         instr_rdata_i = $urandom;
         instr_err_i   = 1'b0;
      end
      #1;
      tgt      = {ba[31:2], 2'b00};
      held     = pend_v;
`ifdef IBEX_PREFETCH_ERR_STOP_EN
      stop_eff = stop_m && !br;
`else
      stop_eff = 0;
`endif
      iss    = rq && !held && !stop_eff && (infl.size() < NumReqs)
             && (br || (fifo.size() + infl.size() < FifoDepth));
      e_req  = held || iss;
      e_addr = held ? pend_addr : (br ? tgt : fetch_a);

      chk("instr_req_o", 32'(instr_req_o), 32'(e_req));
      if (e_req) chk("instr_addr_o", instr_addr_o, e_addr);
      chk("busy_o", 32'(busy_o), 32'(e_req || infl.size() != 0));
      chk("valid_o", 32'(valid_o), 32'(fifo.size() != 0));
      if (fifo.size() != 0) begin
         chk("addr_o", addr_o, fifo[0].addr);
         chk("rdata_o", rdata_o, fifo[0].data);
         chk("err_o", 32'(err_o), 32'(fifo[0].err));
      end

      do_pop = (fifo.size() != 0) && rdy && !br;
      if (do_pop) void'(fifo.pop_front());
      if (rv_eff) begin
         r = infl.pop_front();
         if (!br && !r.stale) begin
            fifo.push_back('{r.addr, memdata(r.addr), memerr(r.addr)});
            if (memerr(r.addr)) stop_m = 1;
         end
      end
      if (br) begin
         fifo.delete();
         foreach (infl[i]) infl[i].stale = 1;
         if (pend_v) pend_stale = 1;
         stop_m = 0;
      end
      if (e_req && g) begin
         infl.push_back('{e_addr, held ? pend_stale : 1'b0});
         pend_v = 0;
      end else if (e_req) begin
         if (!held) pend_stale = 0;
         pend_v = 1;
         pend_addr = e_addr;
      end
      if (iss) fetch_a = e_addr + 32'd4;
      else if (br) fetch_a = tgt;
   endtask

   task automatic drain();
      for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 1, 1);
   endtask

   task automatic chk_reset_zero();
      chk("rst valid_o", 32'(valid_o), 0);
      chk("rst instr_req_o", 32'(instr_req_o), 0);
      chk("rst busy_o", 32'(busy_o), 0);
      chk("rst addr_o", addr_o, 0);
      chk("rst rdata_o", rdata_o, 0);
      chk("rst err_o", 32'(err_o), 0);
   endtask

   initial begin
      rst_i = 1'b1;
      req_i = 0; branch_i = 0; addr_i = '0; ready_i = 0;
      instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0; instr_err_i = 0;
      model_clear();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      #1;
      chk_reset_zero();
      rst_i = 1'b0;

      // Branch with same-cycle grant, then the two-request ceiling
      step(1, 1, 32'h0000_1002, 0, 1, 0);
      chk("t1 first addr", instr_addr_o, 32'h0000_1000);
      step(1, 0, '0, 0, 1, 0);
      chk("t1 second addr", instr_addr_o, 32'h0000_1004);
      step(1, 0, '0, 0, 1, 0);
      chk("t2 req stops", 32'(instr_req_o), 0);
      chk("t2 busy", 32'(busy_o), 1);
      step(1, 0, '0, 0, 1, 1);
      chk("t2 req still off", 32'(instr_req_o), 0);
      step(1, 0, '0, 0, 1, 0);
      chk("t1 valid", 32'(valid_o), 1);
      chk("t1 head addr", addr_o, 32'h0000_1000);
      chk("t1 next req", instr_addr_o, 32'h0000_1008);

      // Branch with two outstanding: both responses dropped
      step(1, 1, 32'h0000_2000, 0, 1, 0);
      chk("t3 no req", 32'(instr_req_o), 0);
      step(1, 0, '0, 0, 1, 1);
      chk("t3 drop1 valid", 32'(valid_o), 0);
      step(1, 0, '0, 0, 1, 1);
      chk("t3 drop2 valid", 32'(valid_o), 0);
      chk("t3 new req", instr_addr_o, 32'h0000_2000);
      step(1, 0, '0, 0, 1, 1);
      chk("t3 latency valid", 32'(valid_o), 0);
      step(1, 0, '0, 0, 1, 0);
      chk("t3 first push", addr_o, 32'h0000_2000);
      chk("t3 first data", rdata_o, memdata(32'h0000_2000));
      drain();

      // Held request survives a branch and its response is dropped
      step(1, 1, 32'h0000_1008, 1, 0, 0);
      chk("t4 held addr", instr_addr_o, 32'h0000_1008);
      step(1, 1, 32'h0000_3000, 1, 0, 0);
      chk("t4 held across branch", instr_addr_o, 32'h0000_1008);
      step(1, 0, '0, 1, 1, 0);
      chk("t4 held granted", instr_addr_o, 32'h0000_1008);
      step(1, 0, '0, 1, 1, 0);
      chk("t4 new target", instr_addr_o, 32'h0000_3000);
      step(1, 0, '0, 1, 1, 1);
      step(1, 0, '0, 1, 1, 1);
      chk("t4 stale dropped", 32'(valid_o), 0);
      step(1, 0, '0, 0, 1, 0);
      chk("t4 head", addr_o, 32'h0000_3000);
      drain();

      // FIFO fill with ready low, then a single pop frees exactly one request
      for (int i = 0; i < 10; i++) step(1, 0, '0, 0, 1, 1);
      chk("t5 full no req", 32'(instr_req_o), 0);
      chk("t5 model full", fifo.size(), FifoDepth);
      step(1, 0, '0, 1, 1, 0);
      chk("t5 pop cycle no req", 32'(instr_req_o), 0);
      step(1, 0, '0, 0, 1, 0);
      chk("t5 one req", 32'(instr_req_o), 1);
      step(1, 0, '0, 0, 1, 0);
      chk("t5 only one", 32'(instr_req_o), 0);
      drain();

      // Bus error tags the 0x4004 entry
      step(1, 1, 32'h0000_4000, 0, 1, 0);
      for (int i = 0; i < 6; i++) step(1, 0, '0, 0, 1, 1);
      step(1, 0, '0, 1, 1, 0);
      chk("t6 head 4000", addr_o, 32'h0000_4000);
      step(1, 0, '0, 0, 1, 0);
      chk("t6 head 4004", addr_o, 32'h0000_4004);
      chk("t6 err", 32'(err_o), 1);
`ifdef IBEX_PREFETCH_ERR_STOP_EN
      chk("t6 stopped", 32'(instr_req_o), 0);
`else
      chk("t6 continues", instr_addr_o, 32'h0000_400C);
`endif
      drain();

      // Random traffic, including wrap near the top of the address space
      for (int n = 0; n < 3000; n++) begin
         bit br;
         logic [31:0] ba;
         br = ($urandom_range(0, 99) < 5);
         ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
         step($urandom_range(0, 9) != 0, br, ba, $urandom_range(0, 9) < 6,
              $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1);
      end

      // Reset in the middle of traffic clears everything; the bus side resets too
      @(negedge clk_i);
      rst_i = 1'b1;
      req_i = 0; branch_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0; ready_i = 0;
      model_clear();
      #1;
      chk_reset_zero();
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int n = 0; n < 200; n++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom,
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
